// File: rtl/taxi_disp_pkg.sv
// -----------------------------------------------------------------------------
// taxi_disp_pkg
// Shared constants for the taximeter display path. The scanner, the tube
// decoder and the top level all use these.
//   DIGIT_W          width of one BCD digit
//   BLANK_CODE       code the decoder renders as an unlit digit
//   DEFAULT_DIGITS   number of display digits on the production board
//   DEFAULT_SCAN_DIV clock cycles each digit stays lit
// -----------------------------------------------------------------------------
package taxi_disp_pkg;

    localparam int         DIGIT_W          = 4;
    localparam logic [3:0] BLANK_CODE       = 4'hF;
    localparam int         DEFAULT_DIGITS   = 8;
    localparam int         DEFAULT_SCAN_DIV = 50000;

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running divider. It counts 0..SCAN_DIV-1, wraps back to 0, and raises
// tick for one cycle on the last count. With SCAN_DIV=1, tick is high on every
// cycle. The divider is also used by other taximeter timebases.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   tick   out  high on the final count of each SCAN_DIV-cycle period
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // At least one bit wide, so that SCAN_DIV=1 still gives a legal counter.
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt;

    assign tick = (pcnt == LAST);

    // The wrap is explicit, so a SCAN_DIV that is not a power of two never
    // lets the counter run past LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
// Time-multiplexed scan driver for the multi-digit seven-segment display.
// Once per frame it takes a snapshot of the packed BCD digits and the
// decimal-point mask. It then lights one digit at a time, holding each digit
// for SCAN_DIV cycles.
// Optional feature: define DISPLAY_LEADING_ZERO_BLANK_EN to blank leading
// zeros. A blanked digit drives BLANK_CODE.
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   digits_bcd     in   packed BCD; digit i is in bits [4i+3:4i], digit 0 rightmost
//   dp_mask        in   decimal-point request per digit
//   decimal_value  out  BCD value of the lit digit, to the tube decoder
//   digit_sel      out  one-hot enable of the lit digit
//   dp             out  decimal point of the lit digit
//   frame_start    out  one-cycle pulse on the first cycle digit 0 is lit
// -----------------------------------------------------------------------------
module display_scanner
    import taxi_disp_pkg::*;
#(
    parameter int DIGITS   = DEFAULT_DIGITS,
    parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIGIT_W*DIGITS-1:0] digits_bcd,
    input  logic [DIGITS-1:0]         dp_mask,
    output logic [DIGIT_W-1:0]        decimal_value,
    output logic [DIGITS-1:0]         digit_sel,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic                           tick;
    logic [IW-1:0]                  idx;
    logic [DIGITS-1:0][DIGIT_W-1:0] snap_bcd;
    logic [DIGITS-1:0]              snap_dp;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // The snapshot is taken only on the edge where idx wraps. A frame therefore
    // always shows one consistent set of digits, whatever the inputs do during it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            snap_bcd    <= '0;
            snap_dp     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (tick) begin
                if (idx == IDX_LAST) begin
                    idx         <= '0;
                    snap_bcd    <= digits_bcd;
                    snap_dp     <= dp_mask;
                    frame_start <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        digit_sel      = '0;
        digit_sel[idx] = 1'b1;
        dp             = snap_dp[idx];
    end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              run_zero;
    logic              run_dp;

    // Scan from the most significant digit down to digit 1. run_zero stays set
    // while every digit seen so far is zero. run_dp becomes set once a decimal
    // point has been seen; that digit and every digit to its right are then
    // shown. Digit 0 is never blanked.
    always_comb begin
        blank    = '0;
        run_zero = 1'b1;
        run_dp   = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run_zero = run_zero && (snap_bcd[i] == '0);
            run_dp   = run_dp | snap_dp[i];
            blank[i] = run_zero & ~run_dp;
        end
    end

    assign decimal_value = blank[idx] ? BLANK_CODE : snap_bcd[idx];
`else
    // Non-BCD nibbles pass straight through. The decoder blanks them.
    assign decimal_value = snap_bcd[idx];
`endif

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

    localparam int D  = 4;
    localparam int SA = 3;
    localparam int SB = 1;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd;
    logic [3:0]  dpm;

    logic [3:0]  a_val, b_val;
    logic [3:0]  a_sel, b_sel;
    logic        a_dp, b_dp, a_fs, b_fs;

    int checks;
    int passes;
    int fails;
    int n;
    logic [15:0] snap_a, snap_b;
    logic [3:0]  sdp_a, sdp_b;

    display_scanner #(.DIGITS(D), .SCAN_DIV(SA)) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .digits_bcd    (bcd),
        .dp_mask       (dpm),
        .decimal_value (a_val),
        .digit_sel     (a_sel),
        .dp            (a_dp),
        .frame_start   (a_fs)
    );

    display_scanner #(.DIGITS(D), .SCAN_DIV(SB)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .digits_bcd    (bcd),
        .dp_mask       (dpm),
        .decimal_value (b_val),
        .digit_sel     (b_sel),
        .dp            (b_dp),
        .frame_start   (b_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s at n=%0d: observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // Rule-level model of what a digit shows: take the nibble from the frame
    // snapshot, then optionally blank it if it is a leading zero.
    function automatic logic [3:0] model_val(input logic [15:0] s, input logic [3:0] m, input int i);
        logic [3:0] nib;
        bit all_zero;
        bit any_dp;
        nib = s[i*4 +: 4];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        if (i > 0) begin
            all_zero = 1'b1;
            any_dp   = 1'b0;
            for (int j = i; j < D; j++) begin
                if (s[j*4 +: 4] != 4'h0) all_zero = 1'b0;
                if (m[j]) any_dp = 1'b1;
            end
            if (all_zero && !any_dp) nib = 4'hF;
        end
`else
        all_zero = 1'b0;
        any_dp   = 1'b0;
`endif
        return nib;
    endfunction

    task automatic check_model();
        int ia;
        int ib;
        ia = (n / SA) % D;
        ib = (n / SB) % D;
        check("a_val", 16'(a_val), 16'(model_val(snap_a, sdp_a, ia)));
        check("a_sel", 16'(a_sel), 16'(1 << ia));
        check("a_dp",  16'(a_dp),  16'(sdp_a[ia]));
        check("a_fs",  16'(a_fs),  16'((n > 0) && (n % (SA*D) == 0)));
        check("b_val", 16'(b_val), 16'(model_val(snap_b, sdp_b, ib)));
        check("b_sel", 16'(b_sel), 16'(1 << ib));
        check("b_dp",  16'(b_dp),  16'(sdp_b[ib]));
        check("b_fs",  16'(b_fs),  16'((n > 0) && (n % (SB*D) == 0)));
    endtask

    // One clock: the model takes its snapshot on the same edge that wraps each
    // DUT's frame, then the outputs are compared 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        n++;
        if (n % (SA*D) == 0) begin snap_a = bcd; sdp_a = dpm; end
        if (n % (SB*D) == 0) begin snap_b = bcd; sdp_b = dpm; end
        #1;
        check_model();
    endtask

    task automatic steps(input int k);
        for (int s = 0; s < k; s++) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_a_val"}, 16'(a_val), 16'h0);
        check({tag, "_a_sel"}, 16'(a_sel), 16'h1);
        check({tag, "_a_dp"},  16'(a_dp),  16'h0);
        check({tag, "_a_fs"},  16'(a_fs),  16'h0);
        check({tag, "_b_sel"}, 16'(b_sel), 16'h1);
        check({tag, "_b_val"}, 16'(b_val), 16'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        n      = 0;
        snap_a = '0; sdp_a = '0;
        snap_b = '0; sdp_b = '0;
        #1;
        check_model();
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0; n = 0;
        snap_a = '0; snap_b = '0; sdp_a = '0; sdp_b = '0;
        rst_n = 1'b0;
        bcd   = 16'h4321;
        dpm   = 4'b0000;
        #1;
        check_reset_vals("rst_hold");
        #20;
        release_reset();

        // Scan order and the first real snapshot.
        steps(12);
        check("order_d0", 16'(a_val), 16'h1);
        steps(6);
        // Change the inputs mid-frame while idx=2; the rest of the frame must not tear.
        bcd = 16'h8765;
        check("tear_d2", 16'(a_val), 16'h3);
        steps(3);
        check("tear_d3", 16'(a_val), 16'h4);
        steps(3);
        check("next_d0", 16'(a_val), 16'h5);
        steps(14);

        // Assert reset asynchronously mid-frame.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        bcd = 16'h0052;
        dpm = 4'b0000;
        release_reset();
        steps(24);
        dpm = 4'b1000;
        steps(24);
        dpm = 4'b0000;
        bcd = 16'h000A;
        steps(24);

        // Random data, with zero nibbles and decimal points made more likely.
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < D; k++)
                    bcd[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                dpm = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            end
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
